// File: rtl/tf_fetch_seq.sv
// Twiddle-factor ROM read sequencer: walks the ROM once per run, absorbs the
// 1-cycle registered read latency, and buffers words for the butterfly unit.
module tf_fetch_seq #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 36,
    parameter int S1_BASE    = 2,
    parameter int S2_BASE    = 10,
    parameter int TOTAL      = 42,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] tf_data,
    output logic [1:0]        tf_stage,
    output logic              tf_stage_last,
    output logic              tf_last,
    output logic              tf_valid,
    input  logic              tf_ready,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = DATA_W + 4;

    localparam logic [ADDR_W-1:0] S1_A   = ADDR_W'(S1_BASE);
    localparam logic [ADDR_W-1:0] S2_A   = ADDR_W'(S2_BASE);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(TOTAL - 1);
    localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W-1:0]  r_cnt;
    logic [ADDR_W-1:0]  r_addr_hold;
    logic               r_inflight;
    logic [3:0]         r_if_tag;
    logic [3:0]         w_issue_tag;
    logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [ENT_W-1:0]   w_head;
    logic               w_push;
    logic               w_pop;
    logic               w_credit_ok;

    // Tag layout: {stage[1:0], stage_last, last}, derived from the issued address
    always_comb begin
        w_issue_tag = 4'b0;
        if (r_cnt < S1_A)      w_issue_tag[3:2] = 2'd0;
        else if (r_cnt < S2_A) w_issue_tag[3:2] = 2'd1;
        else                   w_issue_tag[3:2] = 2'd2;
        w_issue_tag[1] = (r_cnt == S1_A - 1'b1) || (r_cnt == S2_A - 1'b1) || (r_cnt == LAST_A);
        w_issue_tag[0] = (r_cnt == LAST_A);
    end

    assign w_push = r_inflight;
    assign w_pop  = tf_valid && tf_ready;
    // A read may issue only if its word is guaranteed a free slot when it lands
    assign w_credit_ok = (int'(r_count) + int'(r_inflight)) < (FIFO_DEPTH + int'(w_pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        rom_en       = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                rom_en = w_credit_ok;
                if (w_credit_ok && (r_cnt == LAST_A)) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!tf_valid && !r_inflight) begin
                    done         = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_addr_hold <= '0;
            r_inflight  <= 1'b0;
            r_if_tag    <= '0;
        end else begin
            r_inflight <= rom_en;
            if (r_state == ST_IDLE && start) begin
                r_cnt <= '0;
            end else if (rom_en) begin
                r_cnt       <= r_cnt + 1'b1;
                r_addr_hold <= r_cnt;
                r_if_tag    <= w_issue_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {rom_q, r_if_tag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_MAX) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_MAX) ? '0 : r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head   = r_mem[r_rd_ptr];
    assign tf_valid = (r_count != '0);
    assign {tf_data, tf_stage, tf_stage_last, tf_last} = tf_valid ? w_head : '0;
    assign rom_addr = rom_en ? r_cnt : r_addr_hold;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tf_fetch_seq.sv
// Directed bench for tf_fetch_seq with a registered-read ROM model.
module tb_tf_fetch_seq;

    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 36;
    localparam int TOTAL      = 42;
    localparam int FIFO_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              tf_ready = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_en;
    logic [DATA_W-1:0] rom_q = '0;
    logic [DATA_W-1:0] tf_data;
    logic [1:0]        tf_stage;
    logic              tf_stage_last;
    logic              tf_last;
    logic              tf_valid;
    logic              busy;
    logic              done;

    int vectors = 0;
    int miscompares = 0;
    int iss_q[$];
    logic [DATA_W+3:0] out_q[$];
    int done_cnt = 0;

    tf_fetch_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_q(rom_q),
        .tf_data(tf_data), .tf_stage(tf_stage), .tf_stage_last(tf_stage_last),
        .tf_last(tf_last), .tf_valid(tf_valid), .tf_ready(tf_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rom_word(input int a);
        if (a < 2) return 36'h6F9EA3A3F;
        return {12'(a * 97 + 291), 12'(a ^ 1445), 12'(4095 - a)};
    endfunction

    // {stage[1:0], stage_last, last}
    function automatic logic [3:0] exp_tag(input int a);
        logic [1:0] st;
        st = (a < 2) ? 2'd0 : (a < 10) ? 2'd1 : 2'd2;
        return {st, (a == 1 || a == 9 || a == 41), (a == 41)};
    endfunction

    // ROM: registered read; output is junk whenever no read was issued
    always @(posedge clk) begin
        if (rom_en) rom_q <= rom_word(int'(rom_addr));
        else        rom_q <= {4'($urandom), 32'($urandom)};
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rom_en) iss_q.push_back(int'(rom_addr));
            if (tf_valid && tf_ready) out_q.push_back({tf_data, tf_stage, tf_stage_last, tf_last});
            if (done) done_cnt++;
            vectors++;
            if (iss_q.size() - out_q.size() > FIFO_DEPTH) begin
                miscompares++;
                $display("FAIL occupancy: outstanding=%0d allowed<=%0d", iss_q.size() - out_q.size(), FIFO_DEPTH);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        iss_q.delete();
        out_q.delete();
        done_cnt = 0;
    endtask

    task automatic start_run();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int max_cyc, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            tf_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            sample();
            if (done) begin
                ok = 1'b1;
                break;
            end
            next_cycle();
        end
        tf_ready = 1'b1;
        for (int k = 0; k < 4; k++) next_cycle();
    endtask

    task automatic test_reset();
        logic [DATA_W+ADDR_W+7:0] outs;
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        sample();
        outs = {rom_addr, rom_en, tf_valid, tf_data, tf_stage, tf_stage_last, tf_last, busy, done};
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            sample();
            outs = {rom_addr, rom_en, tf_valid, tf_data, tf_stage, tf_stage_last, tf_last, busy, done};
            vectors++;
            if (outs !== '0) begin
                miscompares++;
                $display("FAIL idle_outputs: cycle %0d got %h want 0", c, outs);
            end
        end
        next_cycle();
    endtask

    task automatic test_nominal();
        bit exp_en, exp_valid;
        clear_mon();
        tf_ready = 1'b1;
        start_run();
        for (int c = 1; c <= 48; c++) begin
            sample();
            exp_en = (c >= 1 && c <= TOTAL);
            exp_valid = (c >= 3 && c <= TOTAL + 2);
            vectors++;
            if (rom_en !== exp_en) begin
                miscompares++;
                $display("FAIL nom_rom_en: cycle %0d got %b want %b", c, rom_en, exp_en);
            end
            if (exp_en) begin
                vectors++;
                if (rom_addr !== ADDR_W'(c - 1)) begin
                    miscompares++;
                    $display("FAIL nom_rom_addr: cycle %0d got %0d want %0d", c, rom_addr, c - 1);
                end
            end
            vectors++;
            if (tf_valid !== exp_valid) begin
                miscompares++;
                $display("FAIL nom_tf_valid: cycle %0d got %b want %b", c, tf_valid, exp_valid);
            end
            if (exp_valid) begin
                vectors++;
                if ({tf_data, tf_stage, tf_stage_last, tf_last} !== {rom_word(c - 3), exp_tag(c - 3)}) begin
                    miscompares++;
                    $display("FAIL nom_word%0d: got %h/%0d/%b/%b want %h/%h", c - 3, tf_data, tf_stage,
                             tf_stage_last, tf_last, rom_word(c - 3), exp_tag(c - 3));
                end
            end
            vectors++;
            if (done !== (c == TOTAL + 3)) begin
                miscompares++;
                $display("FAIL nom_done: cycle %0d got %b want %b", c, done, (c == TOTAL + 3));
            end
            vectors++;
            if (busy !== (c <= TOTAL + 3)) begin
                miscompares++;
                $display("FAIL nom_busy: cycle %0d got %b want %b", c, busy, (c <= TOTAL + 3));
            end
            next_cycle();
        end
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL nom_done_count: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        ok = 1'b0;
        clear_mon();
        tf_ready = 1'b1;
        start_run();
        for (int c = 1; c <= 200; c++) begin
            tf_ready = !(c >= 5 && c <= 14);
            sample();
            if (c >= 5 && c <= 14) begin
                vectors++;
                if (rom_en !== 1'b0 || tf_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bp_stall: cycle %0d rom_en=%b tf_valid=%b want 0/1", c, rom_en, tf_valid);
                end
                vectors++;
                if (tf_data !== rom_word(2) || tf_stage !== 2'd1) begin
                    miscompares++;
                    $display("FAIL bp_frozen: cycle %0d got %h/%0d want %h/1", c, tf_data, tf_stage, rom_word(2));
                end
                vectors++;
                if (iss_q.size() - out_q.size() !== FIFO_DEPTH) begin
                    miscompares++;
                    $display("FAIL bp_saturate: cycle %0d outstanding=%0d want %0d", c,
                             iss_q.size() - out_q.size(), FIFO_DEPTH);
                end
            end
            if (done) begin
                ok = 1'b1;
                break;
            end
            next_cycle();
        end
        tf_ready = 1'b1;
        for (int k = 0; k < 4; k++) next_cycle();
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL bp_timeout: done=0 want 1 within 200 cycles");
        end
        vectors++;
        if (out_q.size() !== TOTAL || iss_q.size() !== TOTAL || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL bp_counts: words=%0d issues=%0d dones=%0d want %0d/%0d/1",
                     out_q.size(), iss_q.size(), done_cnt, TOTAL, TOTAL);
        end
        for (int i = 0; i < out_q.size() && i < TOTAL; i++) begin
            vectors++;
            if (out_q[i] !== {rom_word(i), exp_tag(i)} || iss_q[i] !== i) begin
                miscompares++;
                $display("FAIL bp_seq%0d: got %h addr %0d want %h addr %0d", i, out_q[i], iss_q[i],
                         {rom_word(i), exp_tag(i)}, i);
            end
        end
    endtask

    task automatic test_random_ready();
        bit ok;
        clear_mon();
        start_run();
        run_to_done(600, 1'b1, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rnd_timeout: done=0 want 1 within 600 cycles");
        end
        vectors++;
        if (out_q.size() !== TOTAL || iss_q.size() !== TOTAL || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL rnd_counts: words=%0d issues=%0d dones=%0d want %0d/%0d/1",
                     out_q.size(), iss_q.size(), done_cnt, TOTAL, TOTAL);
        end
        for (int i = 0; i < out_q.size() && i < TOTAL; i++) begin
            vectors++;
            if (out_q[i] !== {rom_word(i), exp_tag(i)} || iss_q[i] !== i) begin
                miscompares++;
                $display("FAIL rnd_seq%0d: got %h addr %0d want %h addr %0d", i, out_q[i], iss_q[i],
                         {rom_word(i), exp_tag(i)}, i);
            end
        end
    endtask

    task automatic test_start_while_busy();
        clear_mon();
        tf_ready = 1'b1;
        start_run();
        for (int c = 1; c <= 52; c++) begin
            start = (c == 1 || c == 10 || c == 44 || c == 45);
            sample();
            vectors++;
            if (done !== (c == TOTAL + 3)) begin
                miscompares++;
                $display("FAIL sb_done: cycle %0d got %b want %b", c, done, (c == TOTAL + 3));
            end
            if (c >= TOTAL + 4) begin
                vectors++;
                if (busy !== 1'b0 || rom_en !== 1'b0) begin
                    miscompares++;
                    $display("FAIL sb_idle: cycle %0d busy=%b rom_en=%b want 0/0", c, busy, rom_en);
                end
            end
            next_cycle();
        end
        start = 1'b0;
        vectors++;
        if (out_q.size() !== TOTAL || iss_q.size() !== TOTAL || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL sb_counts: words=%0d issues=%0d dones=%0d want %0d/%0d/1",
                     out_q.size(), iss_q.size(), done_cnt, TOTAL, TOTAL);
        end
        for (int i = 0; i < out_q.size() && i < TOTAL; i++) begin
            vectors++;
            if (out_q[i] !== {rom_word(i), exp_tag(i)} || iss_q[i] !== i) begin
                miscompares++;
                $display("FAIL sb_seq%0d: got %h addr %0d want %h addr %0d", i, out_q[i], iss_q[i],
                         {rom_word(i), exp_tag(i)}, i);
            end
        end
    endtask

    task automatic test_reset_midrun();
        bit ok;
        logic [DATA_W+ADDR_W+7:0] outs;
        clear_mon();
        tf_ready = 1'b1;
        start_run();
        for (int c = 1; c < 20; c++) next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        outs = {rom_addr, rom_en, tf_valid, tf_data, tf_stage, tf_stage_last, tf_last, busy, done};
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got %h want 0", outs);
        end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        clear_mon();
        start_run();
        run_to_done(200, 1'b0, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL mid_timeout: done=0 want 1 within 200 cycles");
        end
        vectors++;
        if (out_q.size() !== TOTAL || iss_q.size() !== TOTAL || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL mid_counts: words=%0d issues=%0d dones=%0d want %0d/%0d/1",
                     out_q.size(), iss_q.size(), done_cnt, TOTAL, TOTAL);
        end
        for (int i = 0; i < out_q.size() && i < TOTAL; i++) begin
            vectors++;
            if (out_q[i] !== {rom_word(i), exp_tag(i)} || iss_q[i] !== i) begin
                miscompares++;
                $display("FAIL mid_seq%0d: got %h addr %0d want %h addr %0d", i, out_q[i], iss_q[i],
                         {rom_word(i), exp_tag(i)}, i);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_random_ready();
        test_start_while_busy();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
